// File: rtl/pe_pkg.sv
// Shared definitions for the double-buffered weight-stationary PE.
// - Default widths for activations, weights and partial sums.
// - sext: sign-extends a value of a given width to a wide signed word.
// - sat_trunc: range-checks a wide sum against a signed ACC_W-bit range and
//   returns the saturated or wrapped result plus an overflow bit.
package pe_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WEIGHT_W = 8;
  localparam int unsigned ACC_W    = 32;

  // Widest supported accumulator; helpers work at MAX_W+1 bits.
  localparam int unsigned MAX_W = 64;

  typedef logic signed [MAX_W:0] wide_t;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] result;
  } sat_t;

  // Treat the low 'width' bits of val as signed and extend to MAX_W+1 bits.
  function automatic wide_t sext(input logic [MAX_W-1:0] val, input int unsigned width);
    wide_t tmp;
    tmp = wide_t'({1'b0, val}) <<< (MAX_W + 1 - width);
    return tmp >>> (MAX_W + 1 - width);
  endfunction

  // Only the low acc_w bits of the returned result are meaningful.
  function automatic sat_t sat_trunc(input wide_t sum, input int unsigned acc_w,
                                     input logic saturate);
    wide_t max_v;
    wide_t min_v;
    sat_t  r;
    max_v    = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
    min_v    = -(wide_t'(1) <<< (acc_w - 1));
    r.ovf    = 1'b0;
    r.result = sum[MAX_W-1:0];
    if (sum > max_v) begin
      r.ovf = 1'b1;
      if (saturate) r.result = max_v[MAX_W-1:0];
    end else if (sum < min_v) begin
      r.ovf = 1'b1;
      if (saturate) r.result = min_v[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_weight_buf.sv
// Double-buffered weight store for one PE.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   weight_in         weight chain input from the PE above
//   weight_shift_in   load weight_in into the shadow register
//   weight_swap_in    promote shadow to active
//   weight_out        shadow register, chain output to the PE below
//   weight_shift_out  weight_shift_in delayed one cycle
//   weight_swap_out   weight_swap_in delayed one cycle, to the right neighbour
//   active            weight currently used by the MAC
module pe_weight_buf #(
  parameter int unsigned WEIGHT_W = pe_pkg::WEIGHT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [WEIGHT_W-1:0] weight_in,
  input  logic                       weight_shift_in,
  input  logic                       weight_swap_in,
  output logic signed [WEIGHT_W-1:0] weight_out,
  output logic                       weight_shift_out,
  output logic                       weight_swap_out,
  output logic signed [WEIGHT_W-1:0] active
);

  // weight_out doubles as the shadow register. A simultaneous swap and shift
  // moves the old shadow into active while the shadow takes weight_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_out       <= '0;
      active           <= '0;
      weight_shift_out <= 1'b0;
      weight_swap_out  <= 1'b0;
    end else begin
      if (weight_swap_in)  active     <= weight_out;
      if (weight_shift_in) weight_out <= weight_in;
      weight_shift_out <= weight_shift_in;
      weight_swap_out  <= weight_swap_in;
    end
  end

endmodule

// File: rtl/pe_dbw.sv
// Weight-stationary systolic PE with double-buffered weights.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   data_in/data_valid_in            activation from the left
//   data_out/data_valid_out          activation to the right (1-cycle delay)
//   weight_in/weight_shift_in        weight chain from above
//   weight_out/weight_shift_out      weight chain to below
//   weight_swap_in/weight_swap_out   swap token, left to right
//   psum_in/psum_valid_in            partial sum from above
//   psum_out/psum_valid_out          partial sum to below
//   ovf/ovf_clr                      sticky overflow flag and its clear
module pe_dbw #(
  parameter int unsigned DATA_W   = pe_pkg::DATA_W,
  parameter int unsigned WEIGHT_W = pe_pkg::WEIGHT_W,
  parameter int unsigned ACC_W    = pe_pkg::ACC_W,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DATA_W-1:0]   data_in,
  input  logic                       data_valid_in,
  output logic signed [DATA_W-1:0]   data_out,
  output logic                       data_valid_out,
  input  logic signed [WEIGHT_W-1:0] weight_in,
  input  logic                       weight_shift_in,
  output logic signed [WEIGHT_W-1:0] weight_out,
  output logic                       weight_shift_out,
  input  logic                       weight_swap_in,
  output logic                       weight_swap_out,
  input  logic signed [ACC_W-1:0]    psum_in,
  input  logic                       psum_valid_in,
  output logic signed [ACC_W-1:0]    psum_out,
  output logic                       psum_valid_out,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  import pe_pkg::MAX_W;
  import pe_pkg::wide_t;
  import pe_pkg::sat_t;
  import pe_pkg::sext;
  import pe_pkg::sat_trunc;

  localparam int unsigned PROD_W = DATA_W + WEIGHT_W;

  logic signed [WEIGHT_W-1:0] active;

  pe_weight_buf #(
    .WEIGHT_W(WEIGHT_W)
  ) u_weight_buf (
    .clk             (clk),
    .rst_n           (rst_n),
    .weight_in       (weight_in),
    .weight_shift_in (weight_shift_in),
    .weight_swap_in  (weight_swap_in),
    .weight_out      (weight_out),
    .weight_shift_out(weight_shift_out),
    .weight_swap_out (weight_swap_out),
    .active          (active)
  );

  logic signed [PROD_W-1:0] prod;
  logic        [ACC_W-1:0]  addend;
  wide_t                    sum;
  sat_t                     sat;
  logic                     fire;

  // active is the pre-swap weight in a swap cycle since it is a register.
  always_comb begin
    fire   = data_valid_in;
    prod   = PROD_W'(data_in) * PROD_W'(active);
    addend = psum_valid_in ? psum_in : '0;
    // Wide enough that the addition itself can never wrap.
    sum    = sext(MAX_W'(addend), ACC_W) + sext(MAX_W'($unsigned(prod)), PROD_W);
    sat    = sat_trunc(sum, ACC_W, SATURATE);
  end

  // Result bits above ACC_W are don't-care.
  logic unused_sat;
  assign unused_sat = ^sat.result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_valid_out <= 1'b0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      data_out       <= data_in;
      data_valid_out <= data_valid_in;
      psum_valid_out <= fire;
      if (fire) psum_out <= sat.result[ACC_W-1:0];
      // Overflow wins over a same-cycle clear.
      if (fire && sat.ovf) ovf <= 1'b1;
      else if (ovf_clr)    ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_dbw.sv
module tb_pe_dbw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic signed [7:0]  data;
  logic               dval;
  logic signed [7:0]  w_in;
  logic               shift;
  logic               swap;
  logic signed [31:0] psum;
  logic signed [15:0] psum16;
  logic               pval;
  logic               clr;
  logic signed [7:0]  b_data;
  logic               b_dval;

  // Top PE (ACC_W=32, saturating)
  logic signed [7:0]  t_data, t_wout;
  logic               t_dval, t_wsh, t_wsw, t_pval, t_ovf;
  logic signed [31:0] t_psum;
  // Bottom PE, fed by the top PE's weight chain
  logic signed [7:0]  bo_data, bo_wout;
  logic               bo_dval, bo_wsh, bo_wsw, bo_pval, bo_ovf;
  logic signed [31:0] bo_psum;
  // 16-bit saturating and wrapping PEs
  logic signed [7:0]  s_data, s_wout, w_data, w_wout;
  logic               s_dval, s_wsh, s_wsw, s_pval, s_ovf;
  logic               w_dval, w_wsh, w_wsw, w_pval, w_ovf;
  logic signed [15:0] s_psum, w_psum;

  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(32), .SATURATE(1'b1)) u_top (
    .clk(clk), .rst_n(rst_n), .data_in(data), .data_valid_in(dval),
    .data_out(t_data), .data_valid_out(t_dval), .weight_in(w_in), .weight_shift_in(shift),
    .weight_out(t_wout), .weight_shift_out(t_wsh), .weight_swap_in(swap),
    .weight_swap_out(t_wsw), .psum_in(psum), .psum_valid_in(pval), .psum_out(t_psum),
    .psum_valid_out(t_pval), .ovf(t_ovf), .ovf_clr(clr)
  );

  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(32), .SATURATE(1'b1)) u_bot (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .data_valid_in(b_dval),
    .data_out(bo_data), .data_valid_out(bo_dval), .weight_in(t_wout),
    .weight_shift_in(t_wsh), .weight_out(bo_wout), .weight_shift_out(bo_wsh),
    .weight_swap_in(swap), .weight_swap_out(bo_wsw), .psum_in(32'sd0),
    .psum_valid_in(1'b0), .psum_out(bo_psum), .psum_valid_out(bo_pval), .ovf(bo_ovf),
    .ovf_clr(1'b0)
  );

  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .data_in(data), .data_valid_in(dval),
    .data_out(s_data), .data_valid_out(s_dval), .weight_in(w_in), .weight_shift_in(shift),
    .weight_out(s_wout), .weight_shift_out(s_wsh), .weight_swap_in(swap),
    .weight_swap_out(s_wsw), .psum_in(psum16), .psum_valid_in(pval), .psum_out(s_psum),
    .psum_valid_out(s_pval), .ovf(s_ovf), .ovf_clr(clr)
  );

  pe_dbw #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .data_in(data), .data_valid_in(dval),
    .data_out(w_data), .data_valid_out(w_dval), .weight_in(w_in), .weight_shift_in(shift),
    .weight_out(w_wout), .weight_shift_out(w_wsh), .weight_swap_in(swap),
    .weight_swap_out(w_wsw), .psum_in(psum16), .psum_valid_in(pval), .psum_out(w_psum),
    .psum_valid_out(w_pval), .ovf(w_ovf), .ovf_clr(clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data = '0; dval = 1'b0; w_in = '0; shift = 1'b0; swap = 1'b0;
    psum = '0; psum16 = '0; pval = 1'b0; clr = 1'b0; b_data = '0; b_dval = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " t_data"}, t_data, 0);
    chk({tag, " t_dval"}, t_dval, 0);
    chk({tag, " t_wout"}, t_wout, 0);
    chk({tag, " t_wsh"}, t_wsh, 0);
    chk({tag, " t_wsw"}, t_wsw, 0);
    chk({tag, " t_psum"}, t_psum, 0);
    chk({tag, " t_pval"}, t_pval, 0);
    chk({tag, " t_ovf"}, t_ovf, 0);
    chk({tag, " bo_psum"}, bo_psum, 0);
    chk({tag, " s_psum"}, s_psum, 0);
    chk({tag, " w_psum"}, w_psum, 0);
  endtask

  typedef struct {
    int d; int dv; int p; int pv; int clr;
    int s_p; int s_v; int s_o; int w_p; int w_o; int t_p;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Run with weight = 1 in every PE; ACC_W=16 PEs overflow at +/-2^15.
    vecs[0] = '{5,    1, 10,     1, 0, 15,     1, 0, 15,     0, 15};
    vecs[1] = '{-4,   1, 3,      0, 0, -4,     1, 0, -4,     0, -4};
    vecs[2] = '{0,    0, 99,     1, 0, -4,     0, 0, -4,     0, -4};
    vecs[3] = '{1,    1, 32767,  1, 0, 32767,  1, 1, -32768, 1, 32768};
    vecs[4] = '{1,    1, 32767,  1, 1, 32767,  1, 1, -32768, 1, 32768};
    vecs[5] = '{0,    0, 0,      0, 1, 32767,  0, 0, -32768, 0, 32768};
    vecs[6] = '{-1,   1, -32768, 1, 0, -32768, 1, 1, 32767,  1, -32769};
    vecs[7] = '{-128, 1, -100,   0, 0, -128,   1, 1, -128,   1, -128};
    vecs[8] = '{3,    1, 0,      0, 1, 3,      1, 0, 3,      0, 3};

    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset: build up state, then assert reset between edges.
    for (int i = 0; i < 4; i++) begin
      data = 8'($urandom); dval = 1'b1; w_in = 8'($urandom); shift = 1'b1; swap = 1'b1;
      psum = 32'($urandom); psum16 = 16'($urandom); pval = 1'b1;
      b_data = 8'($urandom); b_dval = 1'b1;
      step();
    end
    #3 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    idle();
    #2 rst_n = 1'b1;
    step();
    chk_all_zero("rst_release");

    // Weight chain: 5 then -3, then swap.
    w_in = 8'sd5; shift = 1'b1;
    step();
    chk("chain t_wout 1", t_wout, 5);
    chk("chain t_wsh 1", t_wsh, 1);
    chk("chain bo_wout 1", bo_wout, 0);
    w_in = -8'sd3;
    step();
    chk("chain t_wout 2", t_wout, -3);
    chk("chain bo_wout 2", bo_wout, 5);
    chk("chain bo_wsh 2", bo_wsh, 1);
    shift = 1'b0; swap = 1'b1;
    step();
    chk("chain t_wsw", t_wsw, 1);
    chk("chain t_wsh 3", t_wsh, 0);
    chk("chain bo_wout 3", bo_wout, -3);
    swap = 1'b0; data = 8'sd1; dval = 1'b1; b_data = 8'sd1; b_dval = 1'b1;
    step();
    chk("chain top active", t_psum, -3);
    chk("chain bot active", bo_psum, 5);
    chk("chain t_wsw off", t_wsw, 0);

    // MAC with active = -3.
    idle();
    data = 8'sd7; dval = 1'b1; psum = 32'sd100; pval = 1'b1;
    step();
    chk("mac psum", t_psum, 79);
    chk("mac pval", t_pval, 1);
    chk("mac data_out", t_data, 7);
    pval = 1'b0;
    step();
    chk("mac no addend", t_psum, -21);

    // Swap collision: active 2, shadow 9, then swap + shift + MAC together.
    idle();
    w_in = 8'sd2; shift = 1'b1;
    step();
    w_in = 8'sd9; swap = 1'b1;
    step();
    w_in = 8'sd4; data = 8'sd1; dval = 1'b1; psum = 32'sd0; pval = 1'b1;
    step();
    chk("collide psum", t_psum, 2);
    chk("collide shadow", t_wout, 4);
    idle();
    data = 8'sd1; dval = 1'b1;
    step();
    chk("collide new active", t_psum, 9);

    // Load weight 1 everywhere for the table.
    idle();
    w_in = 8'sd1; shift = 1'b1;
    step();
    shift = 1'b0; swap = 1'b1;
    step();
    idle();

    for (int i = 0; i < 9; i++) begin
      data = 8'(vecs[i].d); dval = (vecs[i].dv != 0);
      psum16 = 16'(vecs[i].p); psum = vecs[i].p; pval = (vecs[i].pv != 0);
      clr = (vecs[i].clr != 0);
      step();
      chk($sformatf("vec%0d s_psum", i), s_psum, vecs[i].s_p);
      chk($sformatf("vec%0d s_pval", i), s_pval, vecs[i].s_v);
      chk($sformatf("vec%0d s_ovf", i), s_ovf, vecs[i].s_o);
      chk($sformatf("vec%0d w_psum", i), w_psum, vecs[i].w_p);
      chk($sformatf("vec%0d w_ovf", i), w_ovf, vecs[i].w_o);
      chk($sformatf("vec%0d t_psum", i), t_psum, vecs[i].t_p);
      chk($sformatf("vec%0d t_pval", i), t_pval, vecs[i].s_v);
      chk($sformatf("vec%0d t_ovf", i), t_ovf, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
